// File: rtl/exec_pkg.sv
// exec_pkg: state encoding and instruction type shared by the executor and the upstream fifo
package exec_pkg;
    typedef enum logic [2:0] {IDLE, FETCH, WAIT, EXEC, GAP, DONE} exec_state_t;
    typedef logic [3:0] instr_t;
    localparam instr_t CMD_NOP = 4'b0000;
endpackage

// File: rtl/step_timer.sv
// step_timer: loadable down-counter; expired is high once the count reaches zero
module step_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expired
);
    logic [W-1:0] count;
    always_ff @(posedge clk)
        if (!rst) count <= '0;
        else if (load) count <= load_val;
        else if (en && count != '0) count <= count - 1'b1;
    assign expired = count == '0;
endmodule

// File: rtl/instr_executor.sv
// instr_executor: drains a 4-bit instruction fifo, holding each for STEP_CYCLES then idling GAP_CYCLES
// Optional EXEC_PAUSE_EN adds a pause input that freezes EXEC/GAP timing.
module instr_executor
    import exec_pkg::*;
#(
    parameter int STEP_CYCLES = 50_000_000,
    parameter int GAP_CYCLES  = 5_000_000
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   start,
    input  logic   stop,
`ifdef EXEC_PAUSE_EN
    input  logic   pause,
`endif
    input  logic   fifo_empty,
    input  instr_t fifo_data,
    output logic   fifo_re,
    output instr_t cmd_out,
    output logic   cmd_valid,
    output logic   busy,
    output logic   done
);
    localparam int MAX_CYCLES = STEP_CYCLES > GAP_CYCLES ? STEP_CYCLES : GAP_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] STEP_LOAD = CW'(STEP_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
    exec_state_t state;
    logic hold, expired, step_end, load;
    logic [CW-1:0] load_val;
`ifdef EXEC_PAUSE_EN
    assign hold = pause;
`else
    assign hold = 1'b0;
`endif
    assign step_end = expired && !hold;
    // The timer is reloaded on entry to EXEC (from WAIT) and to GAP (from EXEC).
    assign load = state == WAIT || (state == EXEC && step_end);
    assign load_val = state == WAIT ? STEP_LOAD : GAP_LOAD;
    step_timer #(.W(CW)) u_timer (
        .clk(clk),
        .rst(rst),
        .load(load),
        .load_val(load_val),
        .en(!hold),
        .expired(expired)
    );
    always_ff @(posedge clk) begin
        if (!rst || stop) begin
            state     <= IDLE;
            fifo_re   <= 1'b0;
            cmd_out   <= CMD_NOP;
            cmd_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            fifo_re <= 1'b0;
            done    <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state   <= fifo_empty ? DONE : FETCH;
                    fifo_re <= !fifo_empty;
                    done    <= fifo_empty;
                    busy    <= 1'b1;
                end
                FETCH: state <= WAIT;
                WAIT: begin
                    state     <= EXEC;
                    cmd_out   <= fifo_data;
                    cmd_valid <= 1'b1;
                end
                // A zero-length gap takes the fetch/done decision straight from EXEC.
                EXEC, GAP: if (step_end) begin
                    cmd_out   <= CMD_NOP;
                    cmd_valid <= 1'b0;
                    if (state == EXEC && GAP_CYCLES > 0) state <= GAP;
                    else begin
                        state   <= fifo_empty ? DONE : FETCH;
                        fifo_re <= !fifo_empty;
                        done    <= fifo_empty;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
